// File: rtl/ps2_pkg.sv
// Shared PS/2 frame layout constants and the frame validity check used by the receiver.
package ps2_pkg;

  localparam int   PS2_FRAME_BITS = 11;
  localparam int   PS2_START_IDX  = 0;
  localparam int   PS2_PARITY_IDX = 9;
  localparam int   PS2_STOP_IDX   = 10;
  localparam logic PS2_IDLE_LEVEL = 1'b1;

  // Odd parity: the eight data bits plus the parity bit must XOR to 1.
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[PS2_START_IDX] == 1'b0) &&
           (f[PS2_STOP_IDX] == 1'b1) &&
           (^f[PS2_PARITY_IDX:PS2_START_IDX+1]);
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Pin synchronisers for the raw PS/2 lines and a falling-edge detector on the synced clock.
module ps2_edge_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  logic [2:0] clk_sync;
  logic [1:0] data_sync;

  // Flops come out of reset at the bus idle level so release never looks like an edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= {3{PS2_IDLE_LEVEL}};
      data_sync <= {2{PS2_IDLE_LEVEL}};
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: deserialises 11-bit frames, checks them and queues bytes.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam int             IW       = $clog2(TIMEOUT_CYC);
  localparam logic [3:0]     LAST_BIT = 4'(PS2_FRAME_BITS - 1);
  localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT_CYC - 1);

  logic                      fall;
  logic                      data_s;
  logic [PS2_FRAME_BITS-2:0] shift;
  logic [3:0]                bit_cnt;
  logic [IW-1:0]             idle_cnt;
  logic [AW:0]               w_ptr;
  logic [AW:0]               r_ptr;
  logic [7:0]                mem [FIFO_DEPTH];
  logic [PS2_FRAME_BITS-1:0] frame;
  logic                      frame_done;
  logic                      frame_good;
  logic                      empty;
  logic                      full;
  logic                      pop;
  logic                      push;

  ps2_edge_sync u_sync (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  // The stop bit is never stored; it is judged straight off the line with the other ten.
  assign frame      = {data_s, shift};
  assign frame_done = fall && (bit_cnt == LAST_BIT);
  assign frame_good = frame_done && ps2_frame_ok(frame);

  assign empty = (w_ptr == r_ptr);
  assign full  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
  assign ready = !empty;
  assign pop   = !nextdata_n && ready;
  assign push  = frame_good && (!full || pop);
  assign data  = ready ? mem[r_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift    <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else if (fall) begin
      idle_cnt <= '0;
      if (frame_done) begin
        bit_cnt <= '0;
      end else begin
        shift   <= {data_s, shift[PS2_FRAME_BITS-2:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (bit_cnt != 4'd0) begin
      if (idle_cnt == IDLE_MAX) begin
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      idle_cnt <= '0;
    end
  end

  // When full, a same-cycle pop frees the head slot, which is exactly where w_ptr points.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_done && !ps2_frame_ok(frame);
      if (push) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (pop) begin
        r_ptr    <= r_ptr + 1'b1;
        overflow <= 1'b0;
      end else if (frame_good && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[w_ptr[AW-1:0]] <= frame[PS2_PARITY_IDX-1:PS2_START_IDX+1];
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: a table of single frames plus hand-written FIFO/timeout/reset sequences.
module tb_ps2_frame_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 10;

  typedef struct {
    logic [7:0] b;
    logic       bad_start;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_ready;
    logic [7:0] exp_data;
    int         exp_err;
  } vec_t;

  logic       clk        = 1'b0;
  logic       clrn       = 1'b1;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int total      = 0;
  int bad        = 0;
  int err_cycles = 0;

  vec_t vecs[8];

  always #5 clk = ~clk;

  ps2_frame_rx #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cycles++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain frame; mode 1: pop in the write cycle; mode 2: check ready latency (FIFO empty).
  task automatic apply_stimulus(input logic [7:0] b, input logic bad_start, input logic bad_par,
                                input logic bad_stop, input int mode);
    logic par;
    par = (~^b) ^ bad_par;
    send_bit(bad_start);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    ps2_data = ~bad_stop;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (mode == 1) nextdata_n = 1'b0;
    if (mode == 2) check_output("latency_before", {31'd0, ready}, 32'd0);
    @(negedge clk);
    nextdata_n = 1'b1;
    if (mode == 2) check_output("latency_after", {31'd0, ready}, 32'd1);
    repeat (HALF - 3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_and_check(input string name, input logic [7:0] exp);
    check_output({name, "_ready"}, {31'd0, ready}, 32'd1);
    check_output({name, "_data"}, {24'd0, data}, {24'd0, exp});
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn       = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int e0;

    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 0};
    vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 0};
    vecs[4] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    vecs[6] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE0, 0};
    vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1};

    #2 clrn = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_ready", {31'd0, ready}, 32'd0);
    check_output("rst_data", {24'd0, data}, 32'd0);
    check_output("rst_overflow", {31'd0, overflow}, 32'd0);
    check_output("rst_frame_err", {31'd0, frame_err}, 32'd0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Single valid frame with exact ready latency.
    e0 = err_cycles;
    apply_stimulus(8'h1C, 1'b0, 1'b0, 1'b0, 2);
    check_output("single_data", {24'd0, data}, 32'h1C);
    check_output("single_err", err_cycles - e0, 32'd0);
    pop_and_check("single_pop", 8'h1C);
    check_output("single_empty", {31'd0, ready}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      e0 = err_cycles;
      apply_stimulus(vecs[i].b, vecs[i].bad_start, vecs[i].bad_par, vecs[i].bad_stop, 0);
      check_output($sformatf("v%0d_ready", i), {31'd0, ready}, {31'd0, vecs[i].exp_ready});
      check_output($sformatf("v%0d_data", i), {24'd0, data}, {24'd0, vecs[i].exp_data});
      check_output($sformatf("v%0d_err", i), err_cycles - e0, vecs[i].exp_err);
      if (vecs[i].exp_ready) begin
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        check_output($sformatf("v%0d_drained", i), {31'd0, ready}, 32'd0);
      end
    end

    // Overflow: nine frames into an eight-entry FIFO.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      apply_stimulus(8'(k), 1'b0, 1'b0, 1'b0, 0);
      if (k == 8) check_output("full_no_ovf", {31'd0, overflow}, 32'd0);
    end
    check_output("ovf_set", {31'd0, overflow}, 32'd1);
    pop_and_check("ovf_pop1", 8'h01);
    check_output("ovf_cleared", {31'd0, overflow}, 32'd0);
    for (int k = 2; k <= 8; k++) pop_and_check($sformatf("ovf_pop%0d", k), 8'(k));
    check_output("ovf_empty", {31'd0, ready}, 32'd0);

    // Full FIFO with a pop in the same cycle as the ninth write.
    do_reset();
    for (int k = 1; k <= 8; k++) apply_stimulus(8'(k), 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(8'h09, 1'b0, 1'b0, 1'b0, 1);
    check_output("fullpop_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 2; k <= 9; k++) pop_and_check($sformatf("fullpop_pop%0d", k), 8'(k));
    check_output("fullpop_empty", {31'd0, ready}, 32'd0);

    // Timeout abandons a five-bit fragment without flagging an error.
    do_reset();
    e0 = err_cycles;
    send_bit(1'b0);
    for (int k = 0; k < 4; k++) send_bit(1'b1);
    repeat (TMO + 10) @(negedge clk);
    apply_stimulus(8'hF0, 1'b0, 1'b0, 1'b0, 0);
    check_output("tmo_err", err_cycles - e0, 32'd0);
    pop_and_check("tmo_pop", 8'hF0);
    check_output("tmo_one_entry", {31'd0, ready}, 32'd0);

    // Reset in the middle of a frame with three bytes queued.
    do_reset();
    apply_stimulus(8'h11, 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(8'h22, 1'b0, 1'b0, 1'b0, 0);
    apply_stimulus(8'h33, 1'b0, 1'b0, 1'b0, 0);
    check_output("rmf_queued", {31'd0, ready}, 32'd1);
    send_bit(1'b0);
    for (int k = 0; k < 6; k++) send_bit(k[0]);
    clrn = 1'b0;
    #1;
    check_output("rmf_ready", {31'd0, ready}, 32'd0);
    check_output("rmf_overflow", {31'd0, overflow}, 32'd0);
    check_output("rmf_data", {24'd0, data}, 32'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    e0 = err_cycles;
    apply_stimulus(8'hE0, 1'b0, 1'b0, 1'b0, 0);
    check_output("rmf_err", err_cycles - e0, 32'd0);
    pop_and_check("rmf_pop", 8'hE0);
    check_output("rmf_empty", {31'd0, ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
